decode_stage: RTL and testbench

Instruction-decode stage of the 5-stage pipeline, and the producer that drives the ID/EX pipeline register. Holds the 16×16 general register file with a dedicated R15 write port, decodes the fetched instruction into operands, ALU opcode and sign-extended immediate, and detects load-use hazards. On a hazard it stalls fetch and emits a bubble. On a branch flush it squashes the current instruction.

---
 rtl/decode_stage_pkg.sv | 46 ++++
 rtl/decode_stage_regfile16.sv | 61 ++++++
 rtl/decode_stage.sv | 129 ++++++++++++
 tb/tb_decode_stage.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_stage_pkg.sv
// Shared ISA constants for the decode stage: opcodes, ALU codes,
// instruction field positions and immediate sign-extension helpers.
package decode_stage_pkg;

    // Major opcodes (instruction bits [15:12])
    localparam logic [3:0] OP_RTYPE = 4'h0;
    localparam logic [3:0] OP_BEQ   = 4'h4;
    localparam logic [3:0] OP_BNE   = 4'h5;
    localparam logic [3:0] OP_LOAD  = 4'h8;
    localparam logic [3:0] OP_STORE = 4'hB;
    localparam logic [3:0] OP_JMP   = 4'hC;
    localparam logic [3:0] OP_HALT  = 4'hF;

    // ALU operations chosen by decode for non-R-type instructions
    localparam logic [3:0] ALU_ADD = 4'h0;
    localparam logic [3:0] ALU_SUB = 4'h1;

    // Bubble instruction injected on stall, flush, reset or illegal opcode
    localparam logic [15:0] BUBBLE = 16'h0000;

    // Instruction field positions
    localparam int OP_HI = 15;
    localparam int OP_LO = 12;
    localparam int RA_HI = 11;
    localparam int RA_LO = 8;
    localparam int RB_HI = 7;
    localparam int RB_LO = 4;
    localparam int FN_HI = 3;
    localparam int FN_LO = 0;

    // Register holding mul/div high result or remainder
    localparam logic [3:0] R15_IDX = 4'hF;

    function automatic logic [15:0] sext4(input logic [3:0] v);
        return {{12{v[3]}}, v};
    endfunction

    function automatic logic [15:0] sext8(input logic [7:0] v);
        return {{8{v[7]}}, v};
    endfunction

    function automatic logic [15:0] sext12(input logic [11:0] v);
        return {{4{v[11]}}, v};
    endfunction

endpackage

// File: rtl/decode_stage_regfile16.sv
// 16x16 general register file: two read ports plus an R15 tap, a writeback
// port, a dedicated R15 side-write port, same-cycle bypass and a
// synchronous clear.
import decode_stage_pkg::*;

module regfile16 (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  ra_addr,
    input  logic [3:0]  rb_addr,
    output logic [15:0] ra_data,
    output logic [15:0] rb_data,
    output logic [15:0] r15_data,
    input  logic        wb_en,
    input  logic [3:0]  wb_reg,
    input  logic [15:0] wb_data,
    input  logic        r15_wen,
    input  logic [15:0] r15_wdata
);

    logic [15:0] rf [16];

    // Storage update: clear on reset, otherwise WB port then R15 side port
    // NOTE: the array is cleared with a loop under reset because software
    // relies on every register starting at zero; the R15 side write is
    // placed after the WB write so that, with non-blocking assignments, it
    // wins when both target R15.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++) begin
                rf[i] <= 16'h0000;
            end
        end else begin
            if (wb_en) begin
                rf[wb_reg] <= wb_data;
            end
            if (r15_wen) begin
                rf[R15_IDX] <= r15_wdata;
            end
        end
    end

    // Bypassed read with the same priority as the write path
    function automatic logic [15:0] read_port(input logic [3:0] addr);
        if (r15_wen && addr == R15_IDX) begin
            return r15_wdata;
        end else if (wb_en && wb_reg == addr) begin
            return wb_data;
        end else begin
            return rf[addr];
        end
    endfunction

    // Combinational read ports
    always_comb begin
        ra_data  = read_port(ra_addr);
        rb_data  = read_port(rb_addr);
        r15_data = read_port(R15_IDX);
    end

endmodule

// File: rtl/decode_stage.sv
// Instruction-decode stage: register read, ALU opcode and immediate decode,
// load-use hazard detection, and bubble insertion on stall/flush/reset.
import decode_stage_pkg::*;

module decode_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] Instruction,
    input  logic [15:0] EXInstruction,
    input  logic        Flush,
    input  logic        WBEn,
    input  logic [3:0]  WBReg,
    input  logic [15:0] WBData,
    input  logic        R15WEn,
    input  logic [15:0] R15WData,
    output logic [15:0] OP1,
    output logic [15:0] OP2,
    output logic [15:0] InstructionOut,
    output logic [15:0] SEImmd,
    output logic [15:0] R15,
    output logic [3:0]  ALUOP,
    output logic        Stall
);

    logic [3:0]  op, ra, rb, fn, ex_op, ex_ra;
    logic [15:0] rf_ra, rf_rb, rf_r15;
    logic        valid, uses_ra, uses_rb, hazard;
    logic [3:0]  dec_alu;
    logic [15:0] dec_imm;
    logic        unused_ex;

    assign op    = Instruction[OP_HI:OP_LO];
    assign ra    = Instruction[RA_HI:RA_LO];
    assign rb    = Instruction[RB_HI:RB_LO];
    assign fn    = Instruction[FN_HI:FN_LO];
    assign ex_op = EXInstruction[OP_HI:OP_LO];
    assign ex_ra = EXInstruction[RA_HI:RA_LO];

    // Only the opcode and destination of the EX instruction matter here
    assign unused_ex = ^EXInstruction[RB_HI:FN_LO];

    regfile16 u_rf (
        .clk       (clk),
        .rst       (rst),
        .ra_addr   (ra),
        .rb_addr   (rb),
        .ra_data   (rf_ra),
        .rb_data   (rf_rb),
        .r15_data  (rf_r15),
        .wb_en     (WBEn),
        .wb_reg    (WBReg),
        .wb_data   (WBData),
        .r15_wen   (R15WEn),
        .r15_wdata (R15WData)
    );

    // Opcode decode: validity, source usage, ALU operation and immediate
    // NOTE: every output of this block gets a default first so no path
    // through the case statement can infer a latch.
    always_comb begin
        valid   = 1'b0;
        uses_ra = 1'b0;
        uses_rb = 1'b0;
        dec_alu = ALU_ADD;
        dec_imm = 16'h0000;
        case (op)
            OP_RTYPE: begin
                valid   = 1'b1;
                uses_ra = 1'b1;
                uses_rb = 1'b1;
                dec_alu = fn;
            end
            OP_LOAD: begin
                valid   = 1'b1;
                uses_rb = 1'b1;
                dec_imm = sext4(fn);
            end
            OP_STORE: begin
                valid   = 1'b1;
                uses_ra = 1'b1;
                uses_rb = 1'b1;
                dec_imm = sext4(fn);
            end
            OP_BEQ, OP_BNE: begin
                valid   = 1'b1;
                uses_ra = 1'b1;
                uses_rb = 1'b1;
                dec_alu = ALU_SUB;
                dec_imm = sext8(Instruction[RB_HI:FN_LO]);
            end
            OP_JMP: begin
                valid   = 1'b1;
                dec_imm = sext12(Instruction[RA_HI:FN_LO]);
            end
            OP_HALT: begin
                valid   = 1'b1;
            end
            default: ;
        endcase
    end

    // Load-use hazard: the load in EX writes a register this instruction reads
    assign hazard = (ex_op == OP_LOAD) &&
                    ((uses_ra && ex_ra == ra) || (uses_rb && ex_ra == rb));

    // Output selection: reset and flush override the hazard, which
    // overrides normal decode
    always_comb begin
        InstructionOut = BUBBLE;
        OP1            = 16'h0000;
        OP2            = 16'h0000;
        SEImmd         = 16'h0000;
        ALUOP          = ALU_ADD;
        Stall          = 1'b0;
        R15            = rst ? rf_r15 : 16'h0000;
        if (rst && !Flush) begin
            if (hazard) begin
                Stall = 1'b1;
            end else if (valid) begin
                InstructionOut = Instruction;
                OP1            = rf_ra;
                OP2            = rf_rb;
                SEImmd         = dec_imm;
                ALUOP          = dec_alu;
            end
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage.
module tb_decode_stage;

    logic        clk;
    logic        rst;
    logic [15:0] Instruction;
    logic [15:0] EXInstruction;
    logic        Flush;
    logic        WBEn;
    logic [3:0]  WBReg;
    logic [15:0] WBData;
    logic        R15WEn;
    logic [15:0] R15WData;
    logic [15:0] OP1;
    logic [15:0] OP2;
    logic [15:0] InstructionOut;
    logic [15:0] SEImmd;
    logic [15:0] R15;
    logic [3:0]  ALUOP;
    logic        Stall;

    int passed = 0;
    int total  = 0;

    decode_stage dut (
        .clk            (clk),
        .rst            (rst),
        .Instruction    (Instruction),
        .EXInstruction  (EXInstruction),
        .Flush          (Flush),
        .WBEn           (WBEn),
        .WBReg          (WBReg),
        .WBData         (WBData),
        .R15WEn         (R15WEn),
        .R15WData       (R15WData),
        .OP1            (OP1),
        .OP2            (OP2),
        .InstructionOut (InstructionOut),
        .SEImmd         (SEImmd),
        .R15            (R15),
        .ALUOP          (ALUOP),
        .Stall          (Stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Advance past the next rising edge and clear one-shot controls
    task automatic tick();
        @(posedge clk);
        #1;
        WBEn   = 1'b0;
        R15WEn = 1'b0;
        Flush  = 1'b0;
    endtask

    // Sample combinational outputs half a cycle away from the edge
    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        rst           = 1'b0;
        Instruction   = 16'h0120;
        EXInstruction = 16'h8210;
        Flush         = 1'b0;
        WBEn          = 1'b1;
        WBReg         = 4'd5;
        WBData        = 16'hBEEF;
        R15WEn        = 1'b1;
        R15WData      = 16'h7777;

        // Reset: bubble, no stall even with a hazard pattern, R15 forced 0
        sample();
        check("rst_stall", 16'(Stall), 16'h0000);
        check("rst_iout", InstructionOut, 16'h0000);
        check("rst_op1", OP1, 16'h0000);
        check("rst_r15", R15, 16'h0000);
        tick();
        rst           = 1'b1;
        EXInstruction = 16'h0000;

        // All registers read back zero (writes during reset were ignored)
        for (int i = 0; i < 16; i++) begin
            Instruction = {4'h0, 4'(i), 4'(15 - i), 4'h0};
            sample();
            check($sformatf("clr_op1_r%0d", i), OP1, 16'h0000);
            check($sformatf("clr_op2_r%0d", 15 - i), OP2, 16'h0000);
            check($sformatf("clr_stall_%0d", i), 16'(Stall), 16'h0000);
            tick();
        end

        // WB to R3 with same-cycle bypass, then from storage
        Instruction = 16'h0330;
        WBEn = 1'b1; WBReg = 4'd3; WBData = 16'h1234;
        sample();
        check("byp_op1", OP1, 16'h1234);
        check("byp_op2", OP2, 16'h1234);
        check("byp_iout", InstructionOut, 16'h0330);
        check("byp_alu", 16'(ALUOP), 16'h0000);
        tick();
        sample();
        check("r3_op1", OP1, 16'h1234);
        tick();
        sample();
        check("r3_op2", OP2, 16'h1234);

        // WB and R15 side write both to R15: side write wins
        tick();
        Instruction = 16'h0FF0;
        WBEn = 1'b1; WBReg = 4'hF; WBData = 16'hAAAA;
        R15WEn = 1'b1; R15WData = 16'h5555;
        sample();
        check("r15_byp_op1", OP1, 16'h5555);
        check("r15_byp_r15", R15, 16'h5555);
        tick();
        sample();
        check("r15_reg", R15, 16'h5555);
        check("r15_reg_op2", OP2, 16'h5555);

        // WB to R7 and R15 side write in the same edge both land
        tick();
        WBEn = 1'b1; WBReg = 4'd7; WBData = 16'h0777;
        R15WEn = 1'b1; R15WData = 16'h1111;
        tick();
        Instruction = 16'h07F0;
        sample();
        check("dual_r7", OP1, 16'h0777);
        check("dual_r15", OP2, 16'h1111);
        tick();
        // Restore R15 = 5555; load R1 = 1111, R2 = 2222
        R15WEn = 1'b1; R15WData = 16'h5555;
        WBEn = 1'b1; WBReg = 4'd1; WBData = 16'h1111;
        tick();
        WBEn = 1'b1; WBReg = 4'd2; WBData = 16'h2222;
        tick();

        // Load-use hazard on rb: one-cycle stall with bubble, WB still lands
        Instruction   = 16'h0120;
        EXInstruction = 16'h8210;
        WBEn = 1'b1; WBReg = 4'd4; WBData = 16'h4444;
        sample();
        check("hz_stall", 16'(Stall), 16'h0001);
        check("hz_iout", InstructionOut, 16'h0000);
        check("hz_op1", OP1, 16'h0000);
        check("hz_op2", OP2, 16'h0000);
        check("hz_imm", SEImmd, 16'h0000);
        check("hz_r15", R15, 16'h5555);
        tick();
        EXInstruction = 16'h0000;
        sample();
        check("post_stall", 16'(Stall), 16'h0000);
        check("post_iout", InstructionOut, 16'h0120);
        check("post_op1", OP1, 16'h1111);
        check("post_op2", OP2, 16'h2222);
        check("post_alu", 16'(ALUOP), 16'h0000);
        tick();
        Instruction = 16'h0440;
        sample();
        check("stall_wb_r4", OP1, 16'h4444);

        // Load reads only rb: ra match does not stall
        tick();
        Instruction   = 16'h8230;
        EXInstruction = 16'h8210;
        sample();
        check("ld_nostall", 16'(Stall), 16'h0000);
        check("ld_iout", InstructionOut, 16'h8230);
        check("ld_op2", OP2, 16'h1234);
        check("ld_imm0", SEImmd, 16'h0000);
        Instruction = 16'h823F;
        #1;
        check("ld_immneg", SEImmd, 16'hFFFF);
        Instruction = 16'h8320;
        #1;
        check("ld_rb_stall", 16'(Stall), 16'h0001);
        // Store reads ra: stall
        Instruction = 16'hB237;
        #1;
        check("st_stall", 16'(Stall), 16'h0001);
        // Jump has no sources
        Instruction = 16'hC210;
        #1;
        check("jmp_nostall", 16'(Stall), 16'h0000);
        check("jmp_imm", SEImmd, 16'h0210);
        Instruction = 16'hC800;
        #1;
        check("jmp_immneg", SEImmd, 16'hF800);

        // beq with offset -2, then flushed
        tick();
        EXInstruction = 16'h0000;
        Instruction   = 16'h40FE;
        sample();
        check("beq_alu", 16'(ALUOP), 16'h0001);
        check("beq_imm", SEImmd, 16'hFFFE);
        check("beq_op2", OP2, 16'h5555);
        Flush = 1'b1;
        #1;
        check("flush_iout", InstructionOut, 16'h0000);
        check("flush_imm", SEImmd, 16'h0000);
        check("flush_stall", 16'(Stall), 16'h0000);

        // Hazard and flush together: flush wins
        tick();
        Instruction   = 16'h0120;
        EXInstruction = 16'h8210;
        Flush         = 1'b1;
        sample();
        check("hzfl_stall", 16'(Stall), 16'h0000);
        check("hzfl_iout", InstructionOut, 16'h0000);

        // R-type ALUOP from fn; illegal opcode becomes a bubble
        tick();
        EXInstruction = 16'h0000;
        Instruction   = 16'h0127;
        sample();
        check("rtype_alu", 16'(ALUOP), 16'h0007);
        Instruction = 16'h1234;
        #1;
        check("illegal_iout", InstructionOut, 16'h0000);
        check("illegal_op1", OP1, 16'h0000);

        // Reset asserted mid-stall drops Stall immediately and clears registers
        tick();
        Instruction   = 16'h0120;
        EXInstruction = 16'h8210;
        sample();
        check("pre_rst_stall", 16'(Stall), 16'h0001);
        rst = 1'b0;
        #1;
        check("mid_rst_stall", 16'(Stall), 16'h0000);
        check("mid_rst_r15", R15, 16'h0000);
        tick();
        rst           = 1'b1;
        EXInstruction = 16'h0000;
        Instruction   = 16'h0F30;
        sample();
        check("cleared_r15", OP1, 16'h0000);
        check("cleared_r3", OP2, 16'h0000);
        check("cleared_r15_tap", R15, 16'h0000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
